// File: rtl/det_driver.sv
// ---------------------------------------------------------------------------
// det_driver
//   Buffers an N x N matrix (row-major) written by a host, then hands it to a
//   determinant core: one Start pulse, N*N consecutive element beats, wait for
//   the core's q_Done level, capture det, and return one Ack / res_valid pulse.
//
// Ports
//   Clk, Reset_n           clock; asynchronous active-low reset
//   ld_valid/ld_data       host element offer
//   ld_ready               high only while filling the buffer
//   Start                  one-cycle start pulse to the core
//   elem_valid/data/idx    element stream to the core (idx = row-major index)
//   q_Done, det            core result level and determinant value
//   Ack                    one-cycle acknowledge to the core
//   res_valid, res_det     one-cycle result pulse and last captured determinant
//   busy                   high in every state except FILL
//   err                    watchdog expiry flag
//
// Build option
//   DET_TIMEOUT_EN  when defined, a watchdog counts cycles spent waiting for
//                   q_Done; after TIMEOUT cycles it raises err, pulses Ack
//                   without capturing, and returns to FILL. err clears on the
//                   next accepted host write. When undefined, err is 0 and the
//                   driver waits for q_Done indefinitely.
// ---------------------------------------------------------------------------
module det_driver #(
  parameter int DW      = 32,
  parameter int N       = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     ld_valid,
  input  logic [DW-1:0]            ld_data,
  output logic                     ld_ready,
  output logic                     Start,
  output logic                     elem_valid,
  output logic [DW-1:0]            elem_data,
  output logic [$clog2(N*N)-1:0]   elem_idx,
  input  logic                     q_Done,
  input  logic [DW-1:0]            det,
  output logic                     Ack,
  output logic                     res_valid,
  output logic [DW-1:0]            res_det,
  output logic                     busy,
  output logic                     err
);

  localparam int          NN   = N * N;
  localparam int          IW   = $clog2(NN);
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_START = 3'd1,
    S_ENTER = 3'd2,
    S_WAIT  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  // Element buffer; intentionally not reset. A reset simply forces a full
  // reload because the write pointer returns to 0.
  logic [DW-1:0] buf_mem [NN];

  state_t        state_q,      state_d;
  logic [IW-1:0] ptr_q,        ptr_d;
  logic          start_q,      start_d;
  logic          ack_q,        ack_d;
  logic          res_valid_q,  res_valid_d;
  logic          elem_valid_q, elem_valid_d;
  logic [IW-1:0] elem_idx_q,   elem_idx_d;
  logic [DW-1:0] elem_data_q,  elem_data_d;
  logic [DW-1:0] res_det_q,    res_det_d;
  logic          wr_en;
  logic [IW-1:0] rd_addr;

`ifdef DET_TIMEOUT_EN
  localparam int            WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // -------------------------------------------------------------------------
  // Next-state / next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    start_d      = 1'b0;
    ack_d        = 1'b0;
    res_valid_d  = 1'b0;
    elem_valid_d = 1'b0;
    elem_idx_d   = elem_idx_q;
    elem_data_d  = elem_data_q;
    res_det_d    = res_det_q;
    wr_en        = 1'b0;
    rd_addr      = '0;
`ifdef DET_TIMEOUT_EN
    wd_d         = '0;
    err_d        = err_q;
`endif

    case (state_q)
      S_FILL: begin
        if (ld_valid) begin
          wr_en = 1'b1;
`ifdef DET_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (ptr_q == LAST) begin
            ptr_d   = '0;
            state_d = S_START;
            start_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end

      S_START: begin
        // Prime the first beat so elem_valid rises the cycle after Start.
        state_d      = S_ENTER;
        rd_addr      = '0;
        elem_valid_d = 1'b1;
        elem_idx_d   = '0;
        elem_data_d  = buf_mem[rd_addr];
      end

      S_ENTER: begin
        if (elem_idx_q == LAST) begin
          state_d      = S_WAIT;
          elem_idx_d   = '0;
          elem_data_d  = '0;
        end else begin
          rd_addr      = elem_idx_q + 1'b1;
          elem_valid_d = 1'b1;
          elem_idx_d   = rd_addr;
          elem_data_d  = buf_mem[rd_addr];
        end
      end

      S_WAIT: begin
        if (q_Done) begin
          res_det_d   = det;
          res_valid_d = 1'b1;
          ack_d       = 1'b1;
          state_d     = S_ACK;
        end
`ifdef DET_TIMEOUT_EN
        else if (wd_q == WD_LIMIT) begin
          // Give up on the core: release it with Ack but report no result.
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end

      S_ACK: begin
        // Leaving immediately means a q_Done that is still high is seen only
        // in FILL, where it is ignored.
        state_d = S_FILL;
      end

      default: begin
        state_d = S_FILL;
        ptr_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_FILL;
      ptr_q        <= '0;
      start_q      <= 1'b0;
      ack_q        <= 1'b0;
      res_valid_q  <= 1'b0;
      elem_valid_q <= 1'b0;
      elem_idx_q   <= '0;
      elem_data_q  <= '0;
      res_det_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      start_q      <= start_d;
      ack_q        <= ack_d;
      res_valid_q  <= res_valid_d;
      elem_valid_q <= elem_valid_d;
      elem_idx_q   <= elem_idx_d;
      elem_data_q  <= elem_data_d;
      res_det_q    <= res_det_d;
    end
  end

`ifdef DET_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  // No watchdog in this build; the comparison is constant-false for any
  // legal TIMEOUT so err is a constant 0.
  assign err = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

  // Buffer write port (no reset on storage)
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      buf_mem[ptr_q] <= ld_data;
    end
  end

  assign ld_ready   = (state_q == S_FILL);
  assign busy       = (state_q != S_FILL);
  assign Start      = start_q;
  assign Ack        = ack_q;
  assign res_valid  = res_valid_q;
  assign elem_valid = elem_valid_q;
  assign elem_idx   = elem_idx_q;
  assign elem_data  = elem_data_q;
  assign res_det    = res_det_q;

endmodule

// File: tb/tb_det_driver.sv
module tb_det_driver;

  localparam int DW = 32;
  localparam int N  = 8;
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          start;
  logic          elem_valid;
  logic [DW-1:0] elem_data;
  logic [IW-1:0] elem_idx;
  logic          q_done = 1'b0;
  logic [DW-1:0] det = '0;
  logic          ack;
  logic          res_valid;
  logic [DW-1:0] res_det;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  det_driver #(.DW(DW), .N(N), .TIMEOUT(16)) dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .Start      (start),
    .elem_valid (elem_valid),
    .elem_data  (elem_data),
    .elem_idx   (elem_idx),
    .q_Done     (q_done),
    .det        (det),
    .Ack        (ack),
    .res_valid  (res_valid),
    .res_det    (res_det),
    .busy       (busy),
    .err        (err)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mat [NN];
  logic [DW-1:0] exp_elem_q [$];
  logic [DW-1:0] exp_res_q  [$];
  logic [DW-1:0] last_res = '0;

  // Determinant of the top-left 3x3 block (rest of matrix is identity)
  function automatic logic [DW-1:0] det3();
    int a, b, c, d, e, f, g, h, k;
    a = $signed(mat[0]);  b = $signed(mat[1]);  c = $signed(mat[2]);
    d = $signed(mat[8]);  e = $signed(mat[9]);  f = $signed(mat[10]);
    g = $signed(mat[16]); h = $signed(mat[17]); k = $signed(mat[18]);
    return DW'(a * (e * k - f * h) - b * (d * k - f * g) + c * (d * h - e * g));
  endfunction

  task automatic set_identity();
    for (int i = 0; i < NN; i++) mat[i] = ((i / N) == (i % N)) ? 32'd1 : 32'd0;
  endtask

  task automatic set_spec_matrix();
    set_identity();
    mat[0]  = 32'd6; mat[1]  = 32'd1;  mat[2]  = 32'd1;
    mat[8]  = 32'd4; mat[9]  = -32'sd2; mat[10] = 32'd5;
    mat[16] = 32'd2; mat[17] = 32'd8;  mat[18] = 32'd7;
  endtask

  // Host writes all NN elements, one per cycle; expected stream is queued.
  task automatic load_matrix();
    exp_elem_q.delete();
    for (int i = 0; i < NN; i++) begin
      checks++;
      if (ld_ready !== 1'b1) begin
        failures++;
        $display("FAIL load_ready[%0d] got=%b exp=1", i, ld_ready);
      end
      ld_valid = 1'b1;
      ld_data  = mat[i];
      exp_elem_q.push_back(mat[i]);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_data  = '0;
  endtask

  // Cycle right after the last accepted write: Start pulse only.
  task automatic check_start(input bit ld_noise);
    checks++;
    if (start !== 1'b1 || elem_valid !== 1'b0 || ack !== 1'b0 || busy !== 1'b1 || ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL start_cycle got start=%b ev=%b ack=%b busy=%b rdy=%b exp 1 0 0 1 0",
               start, elem_valid, ack, busy, ld_ready);
    end
    checks++;
    if (res_det !== last_res) begin
      failures++;
      $display("FAIL res_det_hold got=%0d exp=%0d", $signed(res_det), $signed(last_res));
    end
    if (ld_noise) begin
      ld_valid = 1'b1;
      ld_data  = $urandom;
    end
    @(negedge clk);
  endtask

  // Element beats; stop_at >= 0 returns right after checking that index.
  task automatic stream(input int stop_at, input bit ld_noise);
    logic [DW-1:0] exp_d;
    for (int k = 0; k < NN; k++) begin
      exp_d = (exp_elem_q.size() != 0) ? exp_elem_q.pop_front() : 'x;
      checks++;
      if (elem_valid !== 1'b1 || elem_idx !== IW'(k) || elem_data !== exp_d) begin
        failures++;
        $display("FAIL elem[%0d] got v=%b idx=%0d data=%0d exp v=1 idx=%0d data=%0d",
                 k, elem_valid, elem_idx, $signed(elem_data), k, $signed(exp_d));
      end
      checks++;
      if (start !== 1'b0 || ack !== 1'b0 || res_valid !== 1'b0 || (ld_noise && ld_ready !== 1'b0)) begin
        failures++;
        $display("FAIL elem_excl[%0d] got start=%b ack=%b rv=%b rdy=%b exp 0 0 0 0",
                 k, start, ack, res_valid, ld_ready);
      end
      if (k == stop_at) return;
      if (ld_noise) ld_data = $urandom;
      @(negedge clk);
    end
  endtask

  // WAIT phase, core answer, ACK, then hold_after cycles with q_Done still high.
  task automatic finish(input logic [DW-1:0] det_val, input int hold_after, input bit ld_noise);
    logic [DW-1:0] exp_r;
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (elem_valid !== 1'b0 || busy !== 1'b1 || ack !== 1'b0 || res_valid !== 1'b0 || ld_ready !== 1'b0) begin
        failures++;
        $display("FAIL wait[%0d] got ev=%b busy=%b ack=%b rv=%b rdy=%b exp 0 1 0 0 0",
                 w, elem_valid, busy, ack, res_valid, ld_ready);
      end
      if (ld_noise) ld_data = $urandom;
      @(negedge clk);
    end
    q_done = 1'b1;
    det    = det_val;
    exp_res_q.push_back(det_val);
    @(negedge clk);
    exp_r = exp_res_q.pop_front();
    ld_valid = 1'b0;
    checks++;
    if (ack !== 1'b1 || res_valid !== 1'b1 || start !== 1'b0 || elem_valid !== 1'b0) begin
      failures++;
      $display("FAIL ack_cycle got ack=%b rv=%b start=%b ev=%b exp 1 1 0 0", ack, res_valid, start, elem_valid);
    end
    checks++;
    if (res_det !== exp_r) begin
      failures++;
      $display("FAIL res_det got=%0d exp=%0d", $signed(res_det), $signed(exp_r));
    end
    $display("result captured det=%0d", $signed(res_det));
    last_res = exp_r;
    if (hold_after == 0) q_done = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || res_valid !== 1'b0 || ld_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_ack got ack=%b rv=%b rdy=%b busy=%b exp 0 0 1 0", ack, res_valid, ld_ready, busy);
    end
    for (int h = 0; h < hold_after; h++) begin
      @(negedge clk);
      checks++;
      if (ack !== 1'b0 || res_valid !== 1'b0 || ld_ready !== 1'b1 || res_det !== last_res) begin
        failures++;
        $display("FAIL done_hold[%0d] got ack=%b rv=%b rdy=%b res=%0d exp 0 0 1 %0d",
                 h, ack, res_valid, ld_ready, $signed(res_det), $signed(last_res));
      end
    end
    q_done = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (start !== 1'b0 || ack !== 1'b0 || elem_valid !== 1'b0 || elem_idx !== '0 || elem_data !== '0 ||
        res_valid !== 1'b0 || res_det !== '0 || busy !== 1'b0 || err !== 1'b0 || ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got start=%b ack=%b ev=%b idx=%0d data=%0d rv=%b res=%0d busy=%b err=%b rdy=%b",
               start, ack, elem_valid, elem_idx, elem_data, res_valid, res_det, busy, err, ld_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_spec_matrix();
    checks++;
    if ($signed(det3()) != -306) begin
      failures++;
      $display("FAIL model_det got=%0d exp=-306", $signed(det3()));
    end
    load_matrix();
    check_start(1'b0);
    stream(-1, 1'b0);
    finish(det3(), 0, 1'b0);
  endtask

  task automatic test_ignore_ld();
    set_spec_matrix();
    load_matrix();
    check_start(1'b1);
    stream(-1, 1'b1);
    finish(det3(), 0, 1'b1);
    // Reload the same data; the stream must still match it exactly.
    load_matrix();
    check_start(1'b0);
    stream(-1, 1'b0);
    finish(det3(), 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    set_spec_matrix();
    load_matrix();
    check_start(1'b0);
    stream(20, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (start !== 1'b0 || ack !== 1'b0 || elem_valid !== 1'b0 || elem_idx !== '0 || elem_data !== '0 ||
        res_valid !== 1'b0 || res_det !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got start=%b ack=%b ev=%b idx=%0d data=%0d rv=%b res=%0d busy=%b err=%b",
               start, ack, elem_valid, elem_idx, elem_data, res_valid, res_det, busy, err);
    end
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NN; i++) mat[i] = DW'(i * 3 - 50);
    load_matrix();
    check_start(1'b0);
    stream(-1, 1'b0);
    finish(32'd777, 0, 1'b0);
  endtask

  task automatic test_done_hold();
    set_identity();
    mat[9] = 32'd5;
    load_matrix();
    check_start(1'b0);
    stream(-1, 1'b0);
    finish(32'd5, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NN; i++) mat[i] = $urandom;
      load_matrix();
      check_start(1'b0);
      stream(-1, 1'b0);
      finish($urandom, 0, 1'b0);
    end
  endtask

`ifdef DET_TIMEOUT_EN
  task automatic test_timeout();
    set_identity();
    load_matrix();
    check_start(1'b0);
    stream(-1, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (ack !== 1'b0 || err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait[%0d] got ack=%b err=%b exp 0 0", c, ack, err);
      end
      @(negedge clk);
    end
    checks++;
    if (ack !== 1'b1 || err !== 1'b1 || res_valid !== 1'b0 || res_det !== last_res) begin
      failures++;
      $display("FAIL timeout_fire got ack=%b err=%b rv=%b res=%0d exp 1 1 0 %0d",
               ack, err, res_valid, $signed(res_det), $signed(last_res));
    end
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b1 || err !== 1'b1 || ack !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fill got rdy=%b err=%b ack=%b exp 1 1 0", ld_ready, err, ack);
    end
    ld_valid = 1'b1;
    ld_data  = 32'd1;
    @(negedge clk);
    ld_valid = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err_clear got=%b exp=0", err);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignore_ld();
    test_reset_mid();
    test_done_hold();
    test_back_to_back();
`ifdef DET_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout got=expired exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/det_driver.md
DET_DRIVER -- requirements
Module: det_driver

Interface
REQ-001 Parameter DW, default 32: element and determinant width, two's-complement signed.
REQ-002 Parameter N, default 8: matrix order; buffer holds N*N elements, row-major.
REQ-003 Parameter TIMEOUT, default 4096: watchdog limit in cycles; used only under DET_TIMEOUT_EN.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ld_valid  input  1  host offers ld_data this cycle.
REQ-007 ld_data  input  DW  matrix element from host.
REQ-008 ld_ready  output  1  driver accepts ld_data this cycle.
REQ-009 Start  output  1  one-cycle start pulse to determinant core.
REQ-010 elem_valid  output  1  elem_data/elem_idx valid to core this cycle.
REQ-011 elem_data  output  DW  element streamed to core.
REQ-012 elem_idx  output  clog2(N*N)  row-major index of elem_data.
REQ-013 q_Done  input  1  core result-ready level.
REQ-014 det  input  DW  core determinant, valid while q_Done high.
REQ-015 Ack  output  1  one-cycle acknowledge to core.
REQ-016 res_valid  output  1  one-cycle pulse, res_det updated.
REQ-017 res_det  output  DW  last captured determinant.
REQ-018 busy  output  1  high in every state except FILL.
REQ-019 err  output  1  watchdog expiry flag (tied 0 without DET_TIMEOUT_EN).

Function
REQ-020 FSM states SHALL be FILL, START, ENTER, WAIT, ACK; one-hot or encoded is free.
REQ-021 FILL: ld_ready=1; a write is accepted when ld_valid&&ld_ready; element stored at write pointer, pointer increments.
REQ-022 Accepted write with pointer = N*N-1 SHALL transition to START and clear the pointer.
REQ-023 ld_valid outside FILL SHALL be ignored (ld_ready=0, no store).
REQ-024 START: Start=1 for exactly one cycle, then ENTER.
REQ-025 ENTER: elem_valid=1 for exactly N*N consecutive cycles, elem_idx 0..N*N-1 ascending, elem_data = buffer[elem_idx]; after index N*N-1 go to WAIT.
REQ-026 Latency: 64th write accepted at edge T (N=8) -> Start high cycle T+1, elements cycles T+2..T+65, WAIT from T+66.
REQ-027 WAIT: on first cycle q_Done sampled high, capture det into res_det and go to ACK.
REQ-028 ACK: Ack=1 and res_valid=1 for exactly one cycle, then FILL.
REQ-029 q_Done high in any state other than WAIT SHALL be ignored; a still-high q_Done after ACK does not re-trigger capture.
REQ-030 res_det SHALL hold its value until the next capture; arithmetic is pass-through, no sign/width change.
REQ-031 Start, Ack, elem_valid, res_valid SHALL never be high in the same cycle.

Reset
REQ-032 Reset_n low SHALL asynchronously force FILL, pointer 0, Start=0, Ack=0, elem_valid=0, elem_idx=0, elem_data=0, res_valid=0, res_det=0, busy=0, err=0, watchdog=0.
REQ-033 Buffer contents SHALL not be reset; reset mid-operation discards partial fill or stream and requires a full N*N reload.

Configuration
REQ-034 Macro DET_TIMEOUT_EN defined: cycle counter runs in WAIT; reaching TIMEOUT without q_Done sets err=1, pulses Ack (no capture, no res_valid), returns to FILL; err clears on the next accepted write.
REQ-035 DET_TIMEOUT_EN undefined: no counter, err tied 0, WAIT persists indefinitely.

Verification
REQ-036 Load rows [6,1,1,0..],[4,-2,5,0..],[2,8,7,0..] plus identity for rows 3-7; core model returns det -> Start one cycle after 64th write, 64 elem_valid cycles idx 0..63, res_det=-306, Ack and res_valid one cycle.
REQ-037 ld_valid high continuously through START/ENTER/WAIT -> ld_ready=0, buffer unchanged, second run re-streams identical data.
REQ-038 Assert Reset_n low at elem_idx=20 -> all outputs reset value that cycle; next 64 writes restart from index 0.
REQ-039 Core holds q_Done high 5 cycles after Ack -> exactly one capture, one Ack, driver in FILL with ld_ready=1.
REQ-040 DET_TIMEOUT_EN, TIMEOUT=16, q_Done never asserted -> err=1 and Ack pulse 16 cycles into WAIT, res_det unchanged, return to FILL.
